// File: rtl/rsa_xcel_pkg.sv
// Shared types and widths for the RSA accelerator mulrem sharing logic.
// Holds the requester ID type and the mulrem message widths.
package rsa_xcel_pkg;

    localparam int unsigned MULREM_REQ_W  = 96;
    localparam int unsigned MULREM_RESP_W = 32;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_ID_0 = 1'b0;
    localparam req_id_t REQ_ID_1 = 1'b1;

    // Pointer width for a queue of the given depth; a depth of 1 still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rsa_xcel_mulrem_tag_queue.sv
// Synchronous FIFO of requester IDs recording the grant order of in-flight mulrem requests.
// Push is ignored when full and pop is ignored when empty.
module rsa_xcel_mulrem_tag_queue
    import rsa_xcel_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = ptr_width(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  req_id_t push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    req_id_t         mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop_ok) begin
            head_d = ptr_inc(head_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= push_id_i;
        end
    end

`ifndef SYNTHESIS
    no_overflow: assert property (@(posedge clk) disable iff (reset) push_i |-> !full_o);
    no_underflow: assert property (@(posedge clk) disable iff (reset) pop_i |-> !empty_o);
`endif

endmodule

// File: rtl/rsa_xcel_mulrem_arbiter.sv
// Shares one mulrem unit between two requesters, routing each response back by grant order.
// Define RSA_XCEL_MULREM_ARB_RR_EN for round-robin ties; otherwise requester 0 always wins.
module rsa_xcel_mulrem_arbiter
    import rsa_xcel_pkg::*;
#(
    parameter int unsigned REQ_W     = MULREM_REQ_W,
    parameter int unsigned RESP_W    = MULREM_RESP_W,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_val,
    output logic              req0_rdy,
    input  logic [REQ_W-1:0]  req0_msg,
    output logic              resp0_val,
    input  logic              resp0_rdy,
    output logic [RESP_W-1:0] resp0_msg,

    input  logic              req1_val,
    output logic              req1_rdy,
    input  logic [REQ_W-1:0]  req1_msg,
    output logic              resp1_val,
    input  logic              resp1_rdy,
    output logic [RESP_W-1:0] resp1_msg,

    output logic              mr_i_val,
    input  logic              mr_i_rdy,
    output logic [REQ_W-1:0]  mr_i_msg,
    input  logic              mr_o_val,
    output logic              mr_o_rdy,
    input  logic [RESP_W-1:0] mr_o_msg
);

    req_id_t grant;
    req_id_t head_id;
    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    logic    head_rdy;
    logic    any_val;

`ifdef RSA_XCEL_MULREM_ARB_RR_EN
    req_id_t prio_q, prio_d;

    always_comb begin
        if (req0_val && req1_val) begin
            grant = prio_q;
        end else if (req1_val) begin
            grant = REQ_ID_1;
        end else begin
            grant = REQ_ID_0;
        end
    end

    // The loser of the current grant becomes preferred for the next tie.
    always_comb begin
        prio_d = prio_q;
        if (push) begin
            prio_d = ~grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= REQ_ID_0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        if (req0_val) begin
            grant = REQ_ID_0;
        end else if (req1_val) begin
            grant = REQ_ID_1;
        end else begin
            grant = REQ_ID_0;
        end
    end
`endif

    // Request path: the full flag alone blocks issue, so mr_o never reaches mr_i.
    assign any_val  = req0_val | req1_val;
    assign mr_i_val = any_val & ~full & ~reset;
    assign mr_i_msg = (grant == REQ_ID_1) ? req1_msg : req0_msg;
    assign req0_rdy = (grant == REQ_ID_0) & req0_val & mr_i_rdy & ~full & ~reset;
    assign req1_rdy = (grant == REQ_ID_1) & req1_val & mr_i_rdy & ~full & ~reset;
    assign push     = mr_i_val & mr_i_rdy;

    assign head_rdy  = (head_id == REQ_ID_1) ? resp1_rdy : resp0_rdy;
    assign mr_o_rdy  = ~empty & head_rdy & ~reset;
    assign resp0_val = mr_o_val & ~empty & (head_id == REQ_ID_0) & ~reset;
    assign resp1_val = mr_o_val & ~empty & (head_id == REQ_ID_1) & ~reset;
    assign resp0_msg = mr_o_msg;
    assign resp1_msg = mr_o_msg;
    assign pop       = mr_o_val & mr_o_rdy;

    rsa_xcel_mulrem_tag_queue #(
        .DEPTH (MAX_OUTST)
    ) u_tag_queue (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .push_id_i (grant),
        .pop_i     (pop),
        .full_o    (full),
        .empty_o   (empty),
        .head_o    (head_id)
    );

`ifndef SYNTHESIS
    mr_o_needs_outstanding: assert property (@(posedge clk) disable iff (reset)
        mr_o_val |-> !empty);
    req_rdy_exclusive: assert property (@(posedge clk) !(req0_rdy && req1_rdy));
    resp_val_exclusive: assert property (@(posedge clk) !(resp0_val && resp1_val));
`endif

endmodule

// File: tb/tb_rsa_xcel_mulrem_arbiter.sv
// Scoreboard bench for rsa_xcel_mulrem_arbiter: depth-2 and depth-4 instances, one active at a time.
module tb_rsa_xcel_mulrem_arbiter;

`ifdef RSA_XCEL_MULREM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sel4;
    logic        req0_val, req1_val;
    logic [95:0] req0_msg, req1_msg;
    logic        resp0_rdy, resp1_rdy;
    logic        mr_i_rdy;
    logic        resp_en;
    logic        mr_o_val;
    logic [31:0] mr_o_msg;
    logic        mdl_has;

    logic        d2_req0_rdy, d2_req1_rdy, d2_resp0_val, d2_resp1_val;
    logic [31:0] d2_resp0_msg, d2_resp1_msg;
    logic        d2_mr_i_val, d2_mr_o_rdy;
    logic [95:0] d2_mr_i_msg;
    logic        d4_req0_rdy, d4_req1_rdy, d4_resp0_val, d4_resp1_val;
    logic [31:0] d4_resp0_msg, d4_resp1_msg;
    logic        d4_mr_i_val, d4_mr_o_rdy;
    logic [95:0] d4_mr_i_msg;

    logic        obs_req0_rdy, obs_req1_rdy, obs_resp0_val, obs_resp1_val;
    logic [31:0] obs_resp_msg;
    logic        obs_mr_i_val, obs_mr_o_rdy;
    logic [95:0] obs_mr_i_msg;

    int total = 0;
    int bad   = 0;

    logic [96:0] exp_req[$];
    logic [32:0] exp_resp[$];
    logic [31:0] mdl_q[$];
    logic [96:0] mon_req_e;
    logic [32:0] mon_resp_e;

    always #5 clk = ~clk;

    rsa_xcel_mulrem_arbiter #(.REQ_W(96), .RESP_W(32), .MAX_OUTST(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .req0_val  (req0_val & ~sel4),
        .req0_rdy  (d2_req0_rdy),
        .req0_msg  (req0_msg),
        .resp0_val (d2_resp0_val),
        .resp0_rdy (resp0_rdy),
        .resp0_msg (d2_resp0_msg),
        .req1_val  (req1_val & ~sel4),
        .req1_rdy  (d2_req1_rdy),
        .req1_msg  (req1_msg),
        .resp1_val (d2_resp1_val),
        .resp1_rdy (resp1_rdy),
        .resp1_msg (d2_resp1_msg),
        .mr_i_val  (d2_mr_i_val),
        .mr_i_rdy  (mr_i_rdy),
        .mr_i_msg  (d2_mr_i_msg),
        .mr_o_val  (mr_o_val & ~sel4),
        .mr_o_rdy  (d2_mr_o_rdy),
        .mr_o_msg  (mr_o_msg)
    );

    rsa_xcel_mulrem_arbiter #(.REQ_W(96), .RESP_W(32), .MAX_OUTST(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .req0_val  (req0_val & sel4),
        .req0_rdy  (d4_req0_rdy),
        .req0_msg  (req0_msg),
        .resp0_val (d4_resp0_val),
        .resp0_rdy (resp0_rdy),
        .resp0_msg (d4_resp0_msg),
        .req1_val  (req1_val & sel4),
        .req1_rdy  (d4_req1_rdy),
        .req1_msg  (req1_msg),
        .resp1_val (d4_resp1_val),
        .resp1_rdy (resp1_rdy),
        .resp1_msg (d4_resp1_msg),
        .mr_i_val  (d4_mr_i_val),
        .mr_i_rdy  (mr_i_rdy),
        .mr_i_msg  (d4_mr_i_msg),
        .mr_o_val  (mr_o_val & sel4),
        .mr_o_rdy  (d4_mr_o_rdy),
        .mr_o_msg  (mr_o_msg)
    );

    assign obs_req0_rdy  = sel4 ? d4_req0_rdy  : d2_req0_rdy;
    assign obs_req1_rdy  = sel4 ? d4_req1_rdy  : d2_req1_rdy;
    assign obs_resp0_val = sel4 ? d4_resp0_val : d2_resp0_val;
    assign obs_resp1_val = sel4 ? d4_resp1_val : d2_resp1_val;
    assign obs_resp_msg  = sel4 ? (obs_resp1_val ? d4_resp1_msg : d4_resp0_msg)
                                : (obs_resp1_val ? d2_resp1_msg : d2_resp0_msg);
    assign obs_mr_i_val  = sel4 ? d4_mr_i_val  : d2_mr_i_val;
    assign obs_mr_i_msg  = sel4 ? d4_mr_i_msg  : d2_mr_i_msg;
    assign obs_mr_o_rdy  = sel4 ? d4_mr_o_rdy  : d2_mr_o_rdy;
    assign mr_o_val      = resp_en & mdl_has;

    function automatic logic [95:0] op(input int unsigned a, input int unsigned b,
                                       input int unsigned n);
        return {a[31:0], b[31:0], n[31:0]};
    endfunction

    function automatic logic [31:0] mulrem(input logic [95:0] m);
        logic [63:0] p;
        p = {32'b0, m[95:64]} * {32'b0, m[63:32]};
        return 32'(p % {32'b0, m[31:0]});
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Mulrem model: an in-order unit whose results wait until resp_en lets them out.
    always @(posedge clk) begin
        if (reset) begin
            mdl_q.delete();
        end else begin
            if (mr_o_val && obs_mr_o_rdy) void'(mdl_q.pop_front());
            if (obs_mr_i_val && mr_i_rdy) mdl_q.push_back(mulrem(obs_mr_i_msg));
        end
        mdl_has  <= (mdl_q.size() > 0);
        mr_o_msg <= (mdl_q.size() > 0) ? mdl_q[0] : 32'h0;
    end

    // Monitor: every fire is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (obs_mr_i_val && mr_i_rdy) begin
                if (exp_req.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected: actual=fire required=none");
                end else begin
                    mon_req_e = exp_req.pop_front();
                    check("req_grant", {obs_req1_rdy, obs_req0_rdy},
                          mon_req_e[96] ? 2'b10 : 2'b01);
                    check("req_msg", obs_mr_i_msg, mon_req_e[95:0]);
                end
            end
            if ((obs_resp0_val && resp0_rdy) || (obs_resp1_val && resp1_rdy)) begin
                if (exp_resp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: actual=fire required=none");
                end else begin
                    mon_resp_e = exp_resp.pop_front();
                    check("resp_route", {obs_resp1_val, obs_resp0_val},
                          mon_resp_e[32] ? 2'b10 : 2'b01);
                    check("resp_msg", obs_resp_msg, mon_resp_e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req0_val = 1'b0;
        req1_val = 1'b0;
        resp_en  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_txn(input int unsigned id, input logic [95:0] m, input int unsigned r);
        exp_req.push_back({id[0], m});
        exp_resp.push_back({id[0], r[31:0]});
    endtask

    task automatic check_cnt2(input string name, input int unsigned req);
        check(name, 128'(dut2.u_tag_queue.count_q), 128'(req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] m357, m235, m447;
        int unsigned g;
        m357 = op(3, 5, 7);
        m235 = op(2, 3, 5);
        m447 = op(4, 4, 7);
        reset = 1'b1; sel4 = 1'b0; req0_val = 1'b0; req1_val = 1'b0;
        req0_msg = '0; req1_msg = '0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        mr_i_rdy = 1'b0; resp_en = 1'b0;
        tick();
        do_reset();

        // Reset state.
        @(negedge clk);
        check("rst_mr_i_val", obs_mr_i_val, 0);
        check("rst_mr_o_rdy", obs_mr_o_rdy, 0);
        check("rst_req0_rdy", obs_req0_rdy, 0);
        check("rst_resp0_val", obs_resp0_val, 0);
        check_cnt2("rst_count", 0);
        tick();

        // Single requester: 3*5 mod 7 = 1.
        expect_txn(0, m357, 1);
        req0_msg = m357; req0_val = 1'b1; mr_i_rdy = 1'b1;
        @(negedge clk);
        check("t1_req0_rdy", obs_req0_rdy, 1);
        check("t1_req1_rdy", obs_req1_rdy, 0);
        tick();
        req0_val = 1'b0; resp_en = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        @(negedge clk);
        check_cnt2("t1_count1", 1);
        check("t1_mr_i_idle", obs_mr_i_val, 0);
        check("t1_resp0_val", obs_resp0_val, 1);
        check("t1_resp1_val", obs_resp1_val, 0);
        tick();
        resp_en = 1'b0;
        @(negedge clk);
        check_cnt2("t1_count0", 0);
        check("t1_resp0_done", obs_resp0_val, 0);

        // Ties on the depth-4 instance: 2*3 mod 5 = 1, 4*4 mod 7 = 2.
        tick();
        sel4 = 1'b1;
        do_reset();
        req0_msg = m235; req1_msg = m447;
        for (int i = 0; i < 4; i++) begin
            g = RrEn ? (i % 2) : 0;
            expect_txn(g, (g != 0) ? m447 : m235, (g != 0) ? 2 : 1);
        end
        req0_val = 1'b1; req1_val = 1'b1; mr_i_rdy = 1'b1;
        repeat (4) tick();
        req0_val = 1'b0; req1_val = 1'b0;
        @(negedge clk);
        check("t2_count4", 128'(dut4.u_tag_queue.count_q), 4);
        check("t2_full_idle", obs_mr_i_val, 0);
        tick();
        resp_en = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        repeat (4) tick();
        resp_en = 1'b0;
        @(negedge clk);
        check("t2_count0", 128'(dut4.u_tag_queue.count_q), 0);

        // Full queue on the depth-2 instance.
        tick();
        sel4 = 1'b0;
        do_reset();
        req0_msg = m357; req1_msg = m447;
        expect_txn(0, m357, 1);
        expect_txn(0, m357, 1);
        req0_val = 1'b1; mr_i_rdy = 1'b1;
        repeat (2) tick();
        req1_val = 1'b1;
        @(negedge clk);
        check_cnt2("t3_count_full", 2);
        check("t3_mr_i_val", obs_mr_i_val, 0);
        check("t3_req0_rdy", obs_req0_rdy, 0);
        check("t3_req1_rdy", obs_req1_rdy, 0);
        tick();
        resp_en = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        @(negedge clk);
        check("t3_pop_rdy", obs_mr_o_rdy, 1);
        check("t3_no_push_on_pop", obs_mr_i_val, 0);
        tick();
        resp_en = 1'b0;
        g = RrEn ? 1 : 0;
        expect_txn(g, (g != 0) ? m447 : m357, (g != 0) ? 2 : 1);
        @(negedge clk);
        check_cnt2("t3_count_after_pop", 1);
        check("t3_refill_val", obs_mr_i_val, 1);
        tick();
        req0_val = 1'b0; req1_val = 1'b0;
        @(negedge clk);
        check_cnt2("t3_count_refill", 2);
        tick();
        resp_en = 1'b1;
        repeat (2) tick();
        resp_en = 1'b0;
        @(negedge clk);
        check_cnt2("t3_count_drained", 0);

        // Response backpressure with requester 1 at the head.
        tick();
        do_reset();
        expect_txn(1, m447, 2);
        req1_msg = m447; req1_val = 1'b1; mr_i_rdy = 1'b1;
        tick();
        req1_val = 1'b0; resp_en = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b0;
        @(negedge clk);
        check("t4_resp1_val", obs_resp1_val, 1);
        check("t4_resp0_val", obs_resp0_val, 0);
        check("t4_mr_o_rdy_stall", obs_mr_o_rdy, 0);
        tick();
        resp1_rdy = 1'b1;
        @(negedge clk);
        check_cnt2("t4_count_held", 1);
        check("t4_mr_o_rdy_go", obs_mr_o_rdy, 1);
        tick();
        resp_en = 1'b0;
        @(negedge clk);
        check_cnt2("t4_count_popped", 0);

        // Reset with two requests in flight.
        tick();
        do_reset();
        expect_txn(0, m357, 1);
        expect_txn(0, m357, 1);
        req0_msg = m357; req0_val = 1'b1; mr_i_rdy = 1'b1;
        repeat (2) tick();
        req0_val = 1'b0;
        @(negedge clk);
        check_cnt2("t5_count_pre", 2);
`ifdef RSA_XCEL_MULREM_ARB_RR_EN
        check("t5_prio_pre", 128'(dut2.prio_q), 1);
`endif
        tick();
        reset = 1'b1; req0_val = 1'b1; req1_val = 1'b1; resp_en = 1'b1;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        @(negedge clk);
        check("t5_rst_hs", {obs_mr_i_val, obs_req0_rdy, obs_req1_rdy,
                            obs_resp0_val, obs_resp1_val, obs_mr_o_rdy}, 0);
        tick();
        reset = 1'b0; req0_val = 1'b0; req1_val = 1'b0; resp_en = 1'b0;
        exp_resp.delete();
        @(negedge clk);
        check_cnt2("t5_count_post", 0);
`ifdef RSA_XCEL_MULREM_ARB_RR_EN
        check("t5_prio_post", 128'(dut2.prio_q), 0);
`endif
        check("t5_post_hs", {obs_mr_i_val, obs_req0_rdy, obs_req1_rdy,
                             obs_resp0_val, obs_resp1_val, obs_mr_o_rdy}, 0);
        tick();

        check("sb_req_drained", 128'(exp_req.size()), 0);
        check("sb_resp_drained", 128'(exp_resp.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_xcel_mulrem_arbiter.md
# rsa_xcel_mulrem_arbiter

Shares one multiply-remainder (mulrem) unit between two requesters, such as the r-update and b-update paths of a modular-exponentiation controller. It arbitrates requests onto the single unit and remembers the grant order in a small tag queue, so each response goes back to the requester that issued it. All ports use val/rdy handshakes. Placing this block between the exponent controller and one mulrem removes the second mulrem from the accelerator, at the cost of serialised multiplications.

## Interface
Parameters:
- REQ_W, 96, request message width ({a, b, n}, 32 bits each)
- RESP_W, 32, response message width
- MAX_OUTST, 2, maximum number of requests in flight; tag queue depth, ≥1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req0_val / req0_rdy  in/out  1  requester 0 request handshake
- req0_msg  in  REQ_W  requester 0 operands
- resp0_val / resp0_rdy  out/in  1  requester 0 response handshake
- resp0_msg  out  RESP_W  requester 0 result
- req1_* / resp1_*  same as requester 0, for requester 1
- mr_i_val / mr_i_rdy  out/in  1  mulrem request handshake
- mr_i_msg  out  REQ_W  operands forwarded to the mulrem
- mr_o_val / mr_o_rdy  in/out  1  mulrem response handshake
- mr_o_msg  in  RESP_W  mulrem result

## Operation
- **State:**
  - prio: 1 bit; identifies the preferred requester.
  - Tag queue: MAX_OUTST entries, 1-bit requester ID each, with count/head/tail pointers.
- **Grant (combinational, depends only on the val inputs and state):**
  - Both requesters valid: grant = prio.
  - Otherwise: grant = the single valid requester.
- **Request path:**
  - mr_i_val = (req0_val | req1_val) & !full.
  - mr_i_msg = message of the granted requester.
  - reqK_rdy = (grant == K) & (reqK_val) & mr_i_rdy & !full.
  - On mr_i fire: push the grant ID into the tag queue and set prio = ~grant.
- **Response path:**
  - resp0_msg = resp1_msg = mr_o_msg.
  - respK_val = mr_o_val & !empty & (head == K).
  - mr_o_rdy = !empty & resp_head_rdy.
  - On mr_o fire: pop the tag queue.
- **Simultaneous push and pop:** allowed when the queue is neither full nor empty. Count is unchanged and both pointers advance.
- **Full queue:** push is refused even if a pop occurs in the same cycle. This keeps a combinational path from mr_o to mr_i out of the design.
- **Empty queue with mr_o_val high:** this is a protocol error.
  - mr_o_rdy stays 0.
  - A simulation-only assertion fires.
- **Pointer wrap:** head and tail wrap modulo MAX_OUTST. Count is clog2(MAX_OUTST+1) bits wide.
- **Reset:**
  - The queue empties and prio = 0.
  - All rdy/val outputs are 0 in the reset cycle.
  - The mulrem shares this reset, so no stale responses survive it.

## Timing
- Zero added latency on both paths: request and response cross combinationally in the same cycle.
- Throughput is one request per cycle, limited only by mr_i_rdy and queue space.
- Outputs after reset:
  - reqK_rdy = 0 and respK_val = 0.
  - mr_i_val = 0 until a requester raises val.
  - mr_o_rdy = 0.
- prio and the queue update on the clk edge after a fire.
- Val outputs never depend on rdy inputs of the same interface.

## Configuration
- Macro: RSA_XCEL_MULREM_ARB_RR_EN.
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority. Requester 0 always wins ties, prio is not implemented, and requester 1 can starve.

## Structure
- The shared package rsa_xcel_pkg holds:
  - the typedef for the requester ID (1 bit);
  - localparams MULREM_REQ_W = 96 and MULREM_RESP_W = 32.
- One sub-module: rsa_xcel_mulrem_tag_queue, a parameterised synchronous FIFO of requester IDs. Ports: push/pop/full/empty/head.

## Test plan
- **Single requester:**
  - Stimulus: req0 sends {a=3, b=5, n=7}; the mulrem model returns 1.
  - Required: resp0_val with msg 1, resp1_val never asserted, queue returns to empty.
- **Round-robin ties:** both requesters hold val for 4 cycles with mr_i_rdy=1 and MAX_OUTST=4.
  - Required grant order: 0, 1, 0, 1.
  - Required: responses routed in the same order.
- **Full queue:** MAX_OUTST=2, mr_o_val held 0.
  - Required: after two grants, mr_i_val=0 and both req_rdy=0.
  - One response fire followed by one request fire restores a count of 2.
- **Response backpressure:** head tag is 1 and resp1_rdy=0 while mr_o_val=1.
  - Required: mr_o_rdy=0 and the queue is unchanged. Raising resp1_rdy pops the entry.
- **Reset mid-operation:** assert reset with 2 entries in flight.
  - Required: next cycle count=0, prio=0, all handshake outputs 0.
- **Fixed-priority build (RR_EN undefined):** both requesters valid for 3 cycles.
  - Required: req0 is granted all 3 times.
